jtframe_prog_packer: RTL and testbench
======================================

// Module: jtframe_prog_packer
// PURPOSE
//  Consumes the byte stream from the MiSTer download stage: ioctl_rom_wr, ioctl_addr, ioctl_dout.
//  Buffers the bytes in a small FIFO, strips an optional ROM header and maps each byte to an SDRAM bank.
//  Drives the SDRAM programming port (prog_we/prog_addr/prog_data/prog_mask/prog_ba) with a full prog_rdy handshake.
//  Returns dwnld_busy to the download stage, which holds off end-of-download until all data is written.
// PARAMETERS
//  FW        4        log2 FIFO depth (16 entries of {addr[26:0],data[7:0]})
//  HEADER    0        number of leading bytes routed to the header port, never written to SDRAM
//  BA1_START 27'h7FFFFFF  first byte address (after header) of bank 1; all-ones means unused
//  BA2_START 27'h7FFFFFF  first byte address of bank 2; must be >= BA1_START
//  BA3_START 27'h7FFFFFF  first byte address of bank 3; must be >= BA2_START
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  downloading  in   1   download window active (from download stage)
//  ioctl_rom_wr in   1   byte strobe, one cycle per byte
//  ioctl_addr   in   27  byte address
//  ioctl_dout   in   8   byte data
//  ioctl_full   out  1   FIFO holds >= 2^FW-2 entries; upstream must pause
//  header_we    out  1   one-cycle strobe for header bytes
//  header_addr  out  8   header byte index (addr[7:0])
//  header_data  out  8   header byte
//  prog_we      out  1   SDRAM write request, held until prog_rdy
//  prog_addr    out  22  SDRAM word address inside selected bank
//  prog_data    out  16  {byte,byte}
//  prog_mask    out  2   active-low byte enable: addr[0]=0 -> 2'b10, addr[0]=1 -> 2'b01
//  prog_ba      out  2   SDRAM bank
//  prog_rdy     in   1   one-cycle acknowledge from SDRAM controller
//  dwnld_busy   out  1   high while data remains to be written
//  overflow     out  1   sticky: a byte arrived while the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM in IDLE; overflow cleared.
//  Push: each ioctl_rom_wr with addr<HEADER drives header_we on the next cycle with the latched addr/data, with no FIFO entry.
//   Otherwise the entry {addr-HEADER, data} is written to the FIFO.
//  If the FIFO is full, the byte is dropped and overflow is set. It stays set until rst.
//  Push and pop in the same cycle: occupancy is unchanged. Pointers wrap modulo 2^FW.
//  Bank map on the popped address a: ba=3 if a>=BA3_START, else 2 if >=BA2_START, else 1 if >=BA1_START, else 0.
//   off = a - start(ba), computed 27 bits wide. prog_addr = off[22:1]; bits above 22 are discarded.
//  FSM:
//   IDLE: if FIFO not empty, pop the entry, register the outputs and go to REQ. The FIFO read is combinational: the head entry is shown, pop advances it.
//   REQ: prog_we=1 with all prog_* stable. On prog_rdy, prog_we<=0 and go to GAP.
//   GAP: one cycle with prog_we=0, then IDLE.
//   Minimum 3 cycles per byte with immediate prog_rdy; no upper bound, no timeout.
//  prog_rdy outside REQ is ignored.
//  ioctl_full is registered: high when occupancy >= 2^FW-2 after the current push/pop.
//  dwnld_busy is registered: downloading | FIFO not empty | FSM!=IDLE.
//   It falls at the earliest one cycle after the last GAP with downloading low.
//  Downloading falling mid-stream does not flush; the FIFO drains normally.
//  Downloading rising clears neither the FIFO nor overflow.
//  rst mid-transfer aborts at once: prog_we drops asynchronously and buffered bytes are lost.
// STRUCTURE
//  Shared package (jtframe_prog_pkg): FIFO entry width constant (35), bank-select function,
//   mask encoding constants MASK_LO=2'b10, MASK_HI=2'b01.
//  Sub-module jtframe_prog_fifo: parametric sync FIFO (width, FW), full/empty/level outputs, async rst.
//  Top: header split, bank map, 3-state FSM, busy/full/overflow registers.
// TESTING
//  1. HEADER=0, banks unused; write addr 0..3 = 11,22,33,44, prog_rdy 1 cycle after we
//     -> four writes: prog_addr 0,0,1,1; masks 10,01,10,01; data 1111h,2222h,3333h,4444h; ba 0.
//  2. HEADER=4, BA1_START=27'h100; bytes at addr 3,4,0x104
//     -> header_we addr 3; SDRAM write ba0 addr 0 mask 10; ba1 addr 0 mask 10.
//  3. Push 20 back-to-back bytes (FW=4) with prog_rdy stuck low
//     -> ioctl_full high after 14 entries; overflow set at the 17th byte; prog_we stays high.
//  4. Drop downloading with 5 entries queued, prog_rdy every 4 cycles
//     -> dwnld_busy stays 1 until the 5th GAP completes, then 0 the next cycle.
//  5. Assert rst while in REQ with 3 queued entries
//     -> prog_we, dwnld_busy, ioctl_full 0 immediately; after release, no writes with downloading low.
//  6. Push and pop the same cycle at occupancy 1 -> occupancy stays 1, data order preserved.

Source files
------------

// File: rtl/jtframe_prog_pkg.sv
// Shared definitions for the SDRAM programming packer.
//  prog_entry_t : one buffered byte, {addr[26:0], data[7:0]}
//  ENTRY_W      : width of prog_entry_t
//  MASK_LO/HI   : active-low byte enables for the low/high byte of a 16-bit word
//  bank_sel     : maps a post-header byte address to an SDRAM bank
package jtframe_prog_pkg;

   localparam int unsigned ENTRY_W = 35;

   localparam logic [1:0] MASK_LO = 2'b10;
   localparam logic [1:0] MASK_HI = 2'b01;

   typedef struct packed {
      logic [26:0] addr;
      logic [7:0]  data;
   } prog_entry_t;

   // Bank starts are ordered ba1 <= ba2 <= ba3; an all-ones start leaves the bank unused.
   function automatic logic [1:0] bank_sel(input logic [26:0] a,
                                           input logic [26:0] ba1,
                                           input logic [26:0] ba2,
                                           input logic [26:0] ba3);
      if (a >= ba3) return 2'd3;
      if (a >= ba2) return 2'd2;
      if (a >= ba1) return 2'd1;
      return 2'd0;
   endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO with combinational head read.
//  clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//  push/wdata : write request and data; ignored while full
//  pop/rdata  : rdata always shows the head entry; pop advances it (ignored while empty)
//  full/empty : occupancy flags
//  level      : current occupancy, 0..2^FW
module jtframe_prog_fifo #(
   parameter int unsigned W  = 35,
   parameter int unsigned FW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [FW:0]   level
);

   localparam int unsigned DEPTH   = 1 << FW;
   localparam logic [FW:0] DEPTH_L = (FW+1)'(DEPTH);
   localparam logic [FW:0] LVL_ONE = (FW+1)'(1);
   localparam logic [FW-1:0] PTR_ONE = FW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [FW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (level == DEPTH_L);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      level <= level + LVL_ONE;
         else if (!do_push && do_pop) level <= level - LVL_ONE;
      end
   end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Turns the download byte stream into SDRAM programming writes.
//  clk, rst                 : clock, asynchronous active-high reset
//  downloading              : download window active
//  ioctl_rom_wr/addr/dout   : incoming byte strobe, 27-bit byte address, data
//  ioctl_full               : FIFO nearly full, upstream must pause
//  header_we/addr/data      : one-cycle strobe for bytes below HEADER
//  prog_we/addr/data/mask/ba: SDRAM write request, held until prog_rdy
//  prog_rdy                 : one-cycle acknowledge from the SDRAM controller
//  dwnld_busy               : data still pending
//  overflow                 : sticky, a byte was dropped on a full FIFO
module jtframe_prog_packer
   import jtframe_prog_pkg::*;
#(
   parameter int unsigned FW        = 4,
   parameter int unsigned HEADER    = 0,
   parameter logic [26:0] BA1_START = 27'h7FFFFFF,
   parameter logic [26:0] BA2_START = 27'h7FFFFFF,
   parameter logic [26:0] BA3_START = 27'h7FFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic        ioctl_rom_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_full,
   output logic        header_we,
   output logic [7:0]  header_addr,
   output logic [7:0]  header_data,
   output logic        prog_we,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   input  logic        prog_rdy,
   output logic        dwnld_busy,
   output logic        overflow
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int unsigned DEPTH   = 1 << FW;
   localparam logic [FW:0] FULL_AT = (FW+1)'(DEPTH - 2);
   localparam logic [FW:0] LVL_ONE = (FW+1)'(1);
   localparam logic [26:0] HDR_LEN = 27'(HEADER);

   logic               is_hdr, push, pop, accept;
   logic               fifo_full, fifo_empty;
   logic [FW:0]        level, next_level;
   prog_entry_t        wr_entry, head;
   logic [ENTRY_W-1:0] head_bits;
   logic [1:0]         state, state_d, ba_sel;
   logic [22:0]        start, off;

   generate
      if (HEADER == 0) begin : g_no_hdr
         assign is_hdr = 1'b0;
      end else begin : g_hdr
         assign is_hdr = (ioctl_addr < HDR_LEN);
      end
   endgenerate

   assign push          = ioctl_rom_wr & ~is_hdr;
   assign accept        = push & ~fifo_full;
   assign pop           = (state == ST_IDLE) & ~fifo_empty;
   assign wr_entry.addr = ioctl_addr - HDR_LEN;
   assign wr_entry.data = ioctl_dout;
   assign head          = head_bits;

   jtframe_prog_fifo #(
      .W  (ENTRY_W),
      .FW (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Occupancy after this cycle's push/pop, used by the registered flags.
   always_comb begin
      next_level = level;
      if (accept && !pop)      next_level = level + LVL_ONE;
      else if (!accept && pop) next_level = level - LVL_ONE;
   end

   // Only offset bits [22:0] reach the port, so the subtraction is kept 23 bits wide;
   // the low bits of a 27-bit difference are identical.
   assign ba_sel = bank_sel(head.addr, BA1_START, BA2_START, BA3_START);

   always_comb begin
      start = '0;
      unique case (ba_sel)
         2'd0: start = '0;
         2'd1: start = BA1_START[22:0];
         2'd2: start = BA2_START[22:0];
         2'd3: start = BA3_START[22:0];
         default: start = '0;
      endcase
   end

   assign off = head.addr[22:0] - start;

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
         ST_REQ:  if (prog_rdy) state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         prog_we     <= 1'b0;
         prog_addr   <= '0;
         prog_data   <= '0;
         prog_mask   <= '0;
         prog_ba     <= '0;
         header_we   <= 1'b0;
         header_addr <= '0;
         header_data <= '0;
         ioctl_full  <= 1'b0;
         dwnld_busy  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state <= state_d;

         if (pop) begin
            prog_we   <= 1'b1;
            prog_addr <= off[22:1];
            prog_data <= {head.data, head.data};
            prog_mask <= off[0] ? MASK_HI : MASK_LO;
            prog_ba   <= ba_sel;
         end else if (state == ST_REQ && prog_rdy) begin
            prog_we <= 1'b0;
         end

         header_we <= ioctl_rom_wr & is_hdr;
         if (ioctl_rom_wr && is_hdr) begin
            header_addr <= ioctl_addr[7:0];
            header_data <= ioctl_dout;
         end

         ioctl_full <= (next_level >= FULL_AT);
         // Built from next-state values so busy drops in the first idle cycle after GAP.
         dwnld_busy <= downloading | (next_level != '0) | (state_d != ST_IDLE);
         if (push && fifo_full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Bench for jtframe_prog_packer: directed steps plus a randomized stream scored
// against an address-map model of the expected SDRAM and header writes.
module tb_jtframe_prog_packer;

   localparam int unsigned HEADER = 4;
   localparam logic [26:0] B1 = 27'h100;
   localparam logic [26:0] B2 = 27'h1000;
   localparam logic [26:0] B3 = 27'h40000;

   logic        clk, rst, downloading, ioctl_rom_wr, ioctl_full;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout, header_addr, header_data;
   logic        header_we, prog_we, prog_rdy, dwnld_busy, overflow;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask, prog_ba;

   jtframe_prog_packer #(
      .FW        (4),
      .HEADER    (HEADER),
      .BA1_START (B1),
      .BA2_START (B2),
      .BA3_START (B3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .downloading  (downloading),
      .ioctl_rom_wr (ioctl_rom_wr),
      .ioctl_addr   (ioctl_addr),
      .ioctl_dout   (ioctl_dout),
      .ioctl_full   (ioctl_full),
      .header_we    (header_we),
      .header_addr  (header_addr),
      .header_data  (header_data),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .prog_mask    (prog_mask),
      .prog_ba      (prog_ba),
      .prog_rdy     (prog_rdy),
      .dwnld_busy   (dwnld_busy),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ba;
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } wr_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } hdr_t;

   wr_t  exp_q[$];
   hdr_t hdr_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_writes = 0;
   bit   model_on = 1'b1;
   bit   rdy_en = 1'b0;
   bit   rdy_rand = 1'b0;
   int   rdy_delay = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected SDRAM write for one byte, straight from the address-map rules.
   function automatic wr_t model(input logic [26:0] addr, input logic [7:0] d);
      wr_t         w;
      logic [26:0] a, s, off;
      a = addr - 27'(HEADER);
      if (a >= B3)      begin w.ba = 2'd3; s = B3; end
      else if (a >= B2) begin w.ba = 2'd2; s = B2; end
      else if (a >= B1) begin w.ba = 2'd1; s = B1; end
      else              begin w.ba = 2'd0; s = 27'd0; end
      off    = a - s;
      w.addr = 22'((off / 2) % (1 << 22));
      w.data = {d, d};
      w.mask = (a % 2 == 0) ? 2'b10 : 2'b01;
      return w;
   endfunction

   // SDRAM controller stand-in: acknowledges prog_we after rdy_delay cycles.
   initial begin : responder
      int wait_cnt;
      wait_cnt = 0;
      prog_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (prog_rdy) begin
            prog_rdy = 1'b0;
         end else if (prog_we && rdy_en) begin
            if (wait_cnt >= rdy_delay) begin
               prog_rdy = 1'b1;
               wait_cnt = 0;
               if (rdy_rand) rdy_delay = $urandom_range(0, 3);
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Scoreboard and request-stability monitor.
   initial begin : monitor
      bit          prev_wait;
      logic [21:0] p_addr;
      logic [15:0] p_data;
      logic [1:0]  p_mask, p_ba;
      wr_t         w;
      hdr_t        h;
      prev_wait = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 1'b0;
         end else begin
            if (header_we) begin
               check("hdr_expected", hdr_q.size() != 0, 1);
               if (hdr_q.size() != 0) begin
                  h = hdr_q.pop_front();
                  check("hdr_addr", header_addr, h.addr);
                  check("hdr_data", header_data, h.data);
               end
            end
            if (prev_wait) begin
               check("req_held", prog_we, 1);
               check("req_stable", {prog_addr, prog_data, prog_mask, prog_ba},
                     {p_addr, p_data, p_mask, p_ba});
            end
            if (prog_we && prog_rdy) begin
               n_writes++;
               check("wr_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  check("wr_ba", prog_ba, w.ba);
                  check("wr_addr", prog_addr, w.addr);
                  check("wr_data", prog_data, w.data);
                  check("wr_mask", prog_mask, w.mask);
               end
            end
            prev_wait = prog_we && !prog_rdy;
            p_addr = prog_addr;
            p_data = prog_data;
            p_mask = prog_mask;
            p_ba   = prog_ba;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [26:0] a, input logic [7:0] d);
      hdr_t h;
      ioctl_rom_wr = 1'b1;
      ioctl_addr   = a;
      ioctl_dout   = d;
      if (model_on) begin
         if (a < 27'(HEADER)) begin
            h.addr = a[7:0];
            h.data = d;
            hdr_q.push_back(h);
         end else begin
            exp_q.push_back(model(a, d));
         end
      end
      tick(1);
      ioctl_rom_wr = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && hdr_q.size() == 0 && !prog_we) break;
         tick(1);
      end
      check(tag, exp_q.size() + hdr_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ioctl_rom_wr = 1'b0;
      tick(2);
      exp_q.delete();
      hdr_q.delete();
      rst = 1'b0;
      tick(1);
   endtask

   initial begin : main
      int          w0;
      bit          ok, seen;
      logic [26:0] a;

      rst = 1'b1;
      downloading = 1'b0;
      ioctl_rom_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      tick(2);
      check("reset_prog", {prog_we, prog_addr, prog_data, prog_mask, prog_ba}, 0);
      check("reset_hdr", {header_we, header_addr, header_data}, 0);
      check("reset_flags", {ioctl_full, dwnld_busy, overflow}, 0);
      rst = 1'b0;
      tick(1);

      // Four bytes into bank 0 words 0,0,1,1 with immediate acknowledge.
      downloading = 1'b1;
      rdy_en = 1'b1;
      rdy_delay = 0;
      w0 = n_writes;
      push(27'd4, 8'h11);
      push(27'd5, 8'h22);
      push(27'd6, 8'h33);
      push(27'd7, 8'h44);
      drain("drain_four");
      check("four_writes", n_writes - w0, 4);

      // Header byte, bank 0 first byte, bank 1 first byte.
      push(27'd3, 8'hA5);
      check("hdr_strobe", {header_we, header_addr, header_data}, {1'b1, 8'd3, 8'hA5});
      push(27'd4, 8'h5A);
      push(27'h104, 8'hC3);
      drain("drain_hdr");
      check("hdr_no_write", n_writes - w0, 6);

      // Pushes landing on the cycle the FSM pops, keeping the queue short.
      push(27'h20, 8'h01);
      push(27'h21, 8'h02);
      for (int i = 0; i < 6; i++) begin
         push(27'h22 + 27'(i), 8'(8'h10 + i));
         tick(2);
      end
      drain("drain_pushpop");

      // Randomized stream honouring ioctl_full, random acknowledge latency.
      rdy_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: a = 27'($urandom_range(0, 15));
            1: a = 27'($urandom_range(4, 32'(B1) + 8));
            2: a = 27'($urandom_range(32'(B1), 32'(B2) + 8));
            3: a = 27'($urandom_range(32'(B2), 32'(B3) + 8));
            default: a = 27'($urandom);
         endcase
         for (int w = 0; w < 1000 && ioctl_full; w++) tick(1);
         if (ioctl_full) check("full_stuck", ioctl_full, 0);
         push(a, 8'($urandom));
         tick($urandom_range(0, 2));
      end
      drain("drain_random");
      check("no_overflow", overflow, 0);
      check("busy_while_dl", dwnld_busy, 1);
      downloading = 1'b0;
      tick(2);
      check("idle_after_dl", dwnld_busy, 0);

      // Stuck acknowledge: fill past full with one byte already in REQ.
      do_reset();
      rdy_en = 1'b0;
      rdy_rand = 1'b0;
      model_on = 1'b0;
      downloading = 1'b1;
      push(27'h40, 8'h99);
      tick(1);
      check("stuck_req", prog_we, 1);
      for (int k = 1; k <= 20; k++) begin
         push(27'h40 + 27'(k), 8'(k));
         check($sformatf("full_k%0d", k), ioctl_full, k >= 14);
         check($sformatf("ovf_k%0d", k), overflow, k >= 17);
         check($sformatf("we_k%0d", k), prog_we, 1);
      end

      // Downloading falls with five queued; busy must hold until the last GAP.
      do_reset();
      model_on = 1'b1;
      rdy_en = 1'b1;
      rdy_delay = 3;
      downloading = 1'b1;
      w0 = n_writes;
      for (int i = 0; i < 5; i++) push(27'h200 + 27'(i), 8'(8'h60 + i));
      downloading = 1'b0;
      ok = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (n_writes - w0 >= 5) begin
            seen = 1'b1;
            break;
         end
         if (!dwnld_busy) ok = 1'b0;
         tick(1);
      end
      check("five_done", seen, 1);
      check("busy_held", ok, 1);
      check("busy_in_gap", dwnld_busy, 1);
      tick(1);
      check("busy_fall", dwnld_busy, 0);
      check("five_scored", exp_q.size(), 0);

      // Reset in REQ with three queued entries.
      do_reset();
      model_on = 1'b0;
      rdy_en = 1'b0;
      downloading = 1'b1;
      for (int i = 0; i < 4; i++) push(27'h300 + 27'(i), 8'(i));
      tick(2);
      check("pre_rst_req", prog_we, 1);
      rst = 1'b1;
      #1;
      check("rst_async", {prog_we, dwnld_busy, ioctl_full}, 0);
      tick(2);
      rst = 1'b0;
      downloading = 1'b0;
      rdy_en = 1'b1;
      w0 = n_writes;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (prog_we) seen = 1'b1;
      end
      check("no_we_after_rst", seen, 0);
      check("no_wr_after_rst", n_writes - w0, 0);
      check("idle_after_rst", dwnld_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
